// File: rtl/door_motion_controller.sv
// Door motor controller: remote edge detect, pause/reverse on press,
// obstacle auto-reverse, travel-timeout fault and optional auto-close.
// Outputs are Moore-decoded from the state register.
module door_motion_controller #(
  parameter int TRAVEL_MAX = 64,
  parameter int AUTO_CLOSE = 0,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       remote,
  input  logic       open_limit,
  input  logic       closed_limit,
  input  logic       obstacle,
  output logic [1:0] control,
  output logic [2:0] state_o,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_CLOSED     = 3'd0,
    S_OPENING    = 3'd1,
    S_STOP_OPEN  = 3'd2,
    S_OPEN       = 3'd3,
    S_CLOSING    = 3'd4,
    S_STOP_CLOSE = 3'd5,
    S_FAULT      = 3'd6
  } state_e;

  // Last count value of a travel / auto-close interval; the transition fires
  // on that cycle so residency is exactly TRAVEL_MAX / AUTO_CLOSE cycles.
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
  localparam logic [CNT_W-1:0] AC_LAST     = CNT_W'((AUTO_CLOSE == 0) ? 0 : AUTO_CLOSE - 1);
  localparam bit               AC_EN       = (AUTO_CLOSE != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             remote_q;
  logic             press;
  logic             timeout;

  // remote_q resets high so a button held through reset is not a press.
  assign press   = remote & ~remote_q;
  assign timeout = (cnt_q == TRAVEL_LAST);

  // State, timer and remote history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_CLOSED;
      cnt_q    <= '0;
      remote_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      remote_q <= remote;
    end
  end

  // Next-state logic; within each state the earlier test has priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLOSED:     if (press) state_d = S_OPENING;
      S_OPENING: begin
        if (open_limit)   state_d = S_OPEN;
        else if (timeout) state_d = S_FAULT;
        else if (press)   state_d = S_STOP_OPEN;
      end
      S_STOP_OPEN:  if (press) state_d = S_CLOSING;
      S_OPEN: begin
        if (press && !obstacle)                              state_d = S_CLOSING;
        else if (AC_EN && (cnt_q == AC_LAST) && !obstacle)   state_d = S_CLOSING;
      end
      S_CLOSING: begin
        if (closed_limit)  state_d = S_CLOSED;
        else if (obstacle) state_d = S_OPENING;
        else if (timeout)  state_d = S_FAULT;
        else if (press)    state_d = S_STOP_CLOSE;
      end
      S_STOP_CLOSE: if (press) state_d = S_OPENING;
      S_FAULT:      if (press) state_d = S_OPENING;
      default:      state_d = S_FAULT;
    endcase
  end

  // Timer: cleared on any state change, held at 0 in OPEN while the beam is
  // broken, otherwise counts (saturating) in the timed states.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == S_OPEN && obstacle)
      cnt_d = '0;
    else if ((state_q == S_OPENING || state_q == S_CLOSING || state_q == S_OPEN) &&
             (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Moore output decode.
  always_comb begin
    control = 2'b00;
    case (state_q)
      S_OPENING: control = 2'b10;
      S_CLOSING: control = 2'b11;
      default:   control = 2'b00;
    endcase
  end

  assign state_o = state_q;
  assign fault   = (state_q == S_FAULT);

endmodule

// File: doc/door_motion_controller.md
Name: door_motion_controller

Overview:
Parametrised garage/door motor controller. Successor to the two-bit open/close FSM, adding:
- remote edge detection
- pause/reverse on remote presses
- obstacle auto-reverse
- travel-timeout fault
- optional auto-close timer

It sits between debounced remote/limit/obstacle inputs and the motor driver. Outputs are Moore-decoded from the state register.

Parameters:
TRAVEL_MAX, 64, cycles allowed in OPENING or CLOSING before FAULT; legal range 2..2^16.
AUTO_CLOSE, 0, cycles spent in OPEN before automatic CLOSING; 0 disables auto-close.
CNT_W, 16, timer width; must satisfy 2^CNT_W > max(TRAVEL_MAX, AUTO_CLOSE).

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  asynchronous active-high reset.
remote  in  1  remote button level (synchronised upstream); action on rising edge only.
open_limit  in  1  high when door fully open.
closed_limit  in  1  high when door fully closed.
obstacle  in  1  high while beam broken.
control  out  2  motor command: [1]=enable, [0]=direction (0 open, 1 close); 00 idle, 10 opening, 11 closing.
state_o  out  3  current state code.
fault  out  1  high in FAULT.

Behaviour:
- States and codes: CLOSED=0, OPENING=1, STOP_OPEN=2, OPEN=3, CLOSING=4, STOP_CLOSE=5, FAULT=6. Code 7 is illegal and goes to FAULT next cycle.
- Reset state is CLOSED; control=00, state_o=0, fault=0.
- Outputs are a pure function of state, so they change in the cycle after the triggering input is sampled.
- control decode: OPENING→10, CLOSING→11, every other state→00. Never X.
- Remote press detection:
  - press = remote & ~remote_q; remote_q is a register that resets to 1.
  - A button held through reset release does not produce a press; it must be released and pressed again.
- Timer cnt:
  - Cleared to 0 on every state change and on reset.
  - Increments each cycle in OPENING, CLOSING and OPEN; saturates at all-ones.
  - Held at 0 in OPEN while obstacle=1.
- Transitions (priority top-down within each state, otherwise stay):
  - CLOSED: press → OPENING.
  - OPENING: open_limit → OPEN; cnt==TRAVEL_MAX-1 → FAULT; press → STOP_OPEN.
  - STOP_OPEN: press → CLOSING.
  - OPEN:
    - press & ~obstacle → CLOSING.
    - AUTO_CLOSE!=0 & cnt==AUTO_CLOSE-1 & ~obstacle → CLOSING.
    - press while obstacle=1 is ignored.
  - CLOSING: closed_limit → CLOSED; obstacle → OPENING (auto-reverse); cnt==TRAVEL_MAX-1 → FAULT; press → STOP_CLOSE.
  - STOP_CLOSE: press → OPENING.
  - FAULT: motor off, fault=1; press → OPENING (operator recovery). Limits are ignored.
- Residency: a travel state with no other event lasts exactly TRAVEL_MAX cycles. OPEN with auto-close lasts exactly AUTO_CLOSE cycles.
- Simultaneous events:
  - A limit sensor beats obstacle, timeout and press.
  - Obstacle beats timeout and press.
  - Timeout beats press.
- Limit already asserted on entry: e.g. press in CLOSED with open_limit=1 enters OPENING, then goes to OPEN the next cycle. There is no shortcut.
- Reset mid-operation: immediate asynchronous return to CLOSED, control=00, and the timer is cleared. The next press goes to OPENING regardless of door position.

Test Plan:
- Reset with remote=1, then hold remote high 5 cycles → state stays CLOSED, control=00. Release, then pulse remote 1 cycle → state_o=1 and control=10 one cycle later.
- TRAVEL_MAX=8: press from CLOSED, no limits → OPENING for exactly 8 cycles, then state_o=6, fault=1, control=00. Press again → OPENING.
- CLOSING with obstacle asserted on cycle 3 → OPENING next cycle, control=10. Same test with closed_limit and obstacle together → CLOSED.
- AUTO_CLOSE=16: reach OPEN, obstacle high on cycle 10 for 4 cycles → timer restarts. CLOSING is entered 16 cycles after obstacle falls; a press during obstacle is ignored.
- Press sequence CLOSED→OPENING→STOP_OPEN→CLOSING→STOP_CLOSE→OPENING, each 3 cycles apart → control sequence 10, 00, 11, 00, 10.
- Assert rst asynchronously mid-CLOSING (between clock edges) → control=00 and state_o=0 immediately. AUTO_CLOSE=0: OPEN held 1000 cycles without a press → remains OPEN.
